// File: rtl/seq_detect_param.sv
// Serial pattern detector: matches a 1-bit stream against a loadable PAT_W-bit pattern, counts matches.
// Latency: z is combinational (same cycle as the final pattern bit); match_cnt/pattern/history update at the next edge.
// Backpressure: none; en gates bit consumption, load takes priority over en, clr_cnt wins over a coincident match.
module seq_detect_param #(
    parameter int                PAT_W   = 3,
    parameter logic [PAT_W-1:0]  PAT_RST = PAT_W'(3'b101),
    parameter int                CNT_W   = 8
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             x,
    input  logic             en,
    input  logic             overlap,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             clr_cnt,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic [PAT_W-1:0] pattern
);

    localparam int             FW   = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [FW-1:0]  FULL = FW'(PAT_W - 1);

    // hist keeps the last PAT_W-1 consumed bits (newest at LSB); fill counts how many are valid.
    logic [PAT_W-2:0] hist;
    logic [PAT_W-2:0] hist_nxt;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    fill_nxt;
    logic [PAT_W-1:0] window;

    // The candidate match is the stored history followed by the bit on x this cycle.
    assign window = {hist, x};

    // Mealy match flag: only when primed, consuming, not loading and out of reset.
    always_comb begin
        z = en & ~load & ~areset & (fill == FULL) & (window == pattern);
    end

    // Next-state for the history/fill FSM; load flushes, a non-overlapping match restarts from empty.
    always_comb begin
        hist_nxt = hist;
        fill_nxt = fill;
        if (load) begin
            fill_nxt = '0;
        end else if (en) begin
            hist_nxt = window[PAT_W-2:0];
            if (z && !overlap) begin
                fill_nxt = '0;
            end else if (fill != FULL) begin
                fill_nxt = fill + FW'(1);
            end
        end
    end

    // State register for history and fill level.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            hist <= '0;
            fill <= '0;
        end else begin
            hist <= hist_nxt;
            fill <= fill_nxt;
        end
    end

    // Pattern register; reset reverts any loaded pattern to the default.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            pattern <= PAT_RST;
        end else if (load) begin
            pattern <= pat_in;
        end
    end

    // Saturating match counter; a clear discards a coincident match.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            match_cnt <= '0;
        end else if (clr_cnt) begin
            match_cnt <= '0;
        end else if (z && (match_cnt != {CNT_W{1'b1}})) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: two instances (default counter, 2-bit counter) share one stimulus stream.
// Latency: expected values pushed per cycle by the driver, compared by a monitor on the falling edge.
// Backpressure: none; the monitor pops one entry per cycle whenever one is pending.
module tb_seq_detect_param;

    localparam int PW = 3;

    logic          clk;
    logic          areset;
    logic          x;
    logic          en;
    logic          overlap;
    logic          load;
    logic [PW-1:0] pat_in;
    logic          clr_cnt;

    logic          z_a;
    logic [7:0]    cnt_a;
    logic [PW-1:0] pat_a;
    logic          z_b;
    logic [1:0]    cnt_b;
    logic [PW-1:0] pat_b;

    seq_detect_param dut_a (
        .clk(clk), .areset(areset), .x(x), .en(en), .overlap(overlap), .load(load),
        .pat_in(pat_in), .clr_cnt(clr_cnt), .z(z_a), .match_cnt(cnt_a), .pattern(pat_a)
    );

    seq_detect_param #(.PAT_W(3), .PAT_RST(3'b101), .CNT_W(2)) dut_b (
        .clk(clk), .areset(areset), .x(x), .en(en), .overlap(overlap), .load(load),
        .pat_in(pat_in), .clr_cnt(clr_cnt), .z(z_b), .match_cnt(cnt_b), .pattern(pat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       z;
        int       cnt_a;
        int       cnt_b;
        bit [2:0] pat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: bits consumed since the last restart point; a match is the last PW bits equal to the pattern.
    bit       m_bits[$];
    bit [2:0] m_pat;
    int       m_cnt_a;
    int       m_cnt_b;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_pat   = 3'b101;
        m_cnt_a = 0;
        m_cnt_b = 0;
    endtask

    function automatic bit model_match(input bit xi);
        int v;
        if (m_bits.size() < PW - 1) return 1'b0;
        v = 0;
        for (int i = m_bits.size() - (PW - 1); i < m_bits.size(); i++) v = (v << 1) | int'(m_bits[i]);
        v = (v << 1) | int'(xi);
        return v == int'(m_pat);
    endfunction

    // Drive one cycle (called at posedge+1), record expectations, advance the model, move to next posedge+1.
    task automatic step(input bit xi, input bit ei, input bit oi, input bit li,
                        input bit [2:0] pi, input bit ci);
        exp_t e;
        bit   zm;
        x = xi; en = ei; overlap = oi; load = li; pat_in = pi; clr_cnt = ci;
        zm = ei && !li && model_match(xi);
        e.z = zm; e.cnt_a = m_cnt_a; e.cnt_b = m_cnt_b; e.pat = m_pat;
        exp_q.push_back(e);
        if (li) begin
            m_pat = pi;
            m_bits.delete();
        end else if (ei) begin
            if (zm && !oi) m_bits.delete();
            else begin
                m_bits.push_back(xi);
                while (m_bits.size() > PW - 1) void'(m_bits.pop_front());
            end
        end
        if (ci) begin
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else if (zm) begin
            if (m_cnt_a < 255) m_cnt_a++;
            if (m_cnt_b < 3) m_cnt_b++;
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous mid-cycle reset with immediate output checks, released one edge later.
    task automatic async_reset(input string tag);
        #2;
        areset = 1'b1;
        model_reset();
        #1;
        chk({tag, "_z"}, int'(z_a), 0);
        chk({tag, "_cnt_a"}, int'(cnt_a), 0);
        chk({tag, "_cnt_b"}, int'(cnt_b), 0);
        chk({tag, "_pat"}, int'(pat_a), 5);
        en = 1'b0; load = 1'b0; clr_cnt = 1'b0;
        @(posedge clk);
        #1;
        areset = 1'b0;
    endtask

    // Monitor: compare every pending expectation against both instances on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("z_a", int'(z_a), int'(e.z));
                chk("z_b", int'(z_b), int'(e.z));
                chk("cnt_a", int'(cnt_a), e.cnt_a);
                chk("cnt_b", int'(cnt_b), e.cnt_b);
                chk("pattern", int'(pat_a), int'(e.pat));
                chk("pattern_b", int'(pat_b), int'(e.pat));
            end
        end
    end

    initial begin
        bit [8:0] s9;
        areset = 1'b1; x = 1'b0; en = 1'b0; overlap = 1'b1; load = 1'b0; pat_in = '0; clr_cnt = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_z", int'(z_a), 0);
        chk("rst_cnt", int'(cnt_a), 0);
        chk("rst_pat", int'(pat_a), 5);
        areset = 1'b0;

        // Overlapping 10101: matches on bits 3 and 5.
        step(1,1,1,0,0,0); step(0,1,1,0,0,0); step(1,1,1,0,0,0); step(0,1,1,0,0,0); step(1,1,1,0,0,0);
        chk("ovl_cnt", int'(cnt_a), 2);
        async_reset("r1");

        // Non-overlapping 10101: only bit 3 matches.
        step(1,1,0,0,0,0); step(0,1,0,0,0,0); step(1,1,0,0,0,0); step(0,1,0,0,0,0); step(1,1,0,0,0,0);
        chk("novl_cnt", int'(cnt_a), 1);
        async_reset("r2");

        // Load 110 after two consumed ones; the prefix is discarded.
        step(1,1,1,0,0,0); step(1,1,1,0,0,0); step(1,1,1,1,3'b110,0); step(0,1,1,0,0,0);
        step(1,1,1,0,0,0); step(1,1,1,0,0,0); step(0,1,1,0,0,0);
        chk("load_pat", int'(pat_a), 6);
        chk("load_cnt", int'(cnt_a), 1);
        async_reset("r3");

        // Gapped stream with random x while en is low.
        s9 = 9'b101;
        for (int i = 2; i >= 0; i--) begin
            step(s9[i],1,1,0,0,0);
            step(1'($urandom), 0, 1, 0, 0, 0);
            step(1'($urandom), 0, 1, 0, 0, 0);
        end
        chk("gap_cnt", int'(cnt_a), 1);
        async_reset("r4");

        // Saturation of the 2-bit counter, then clear coincident with a match.
        s9 = 9'b101010101;
        for (int i = 8; i >= 0; i--) step(s9[i],1,1,0,0,0);
        chk("sat_cnt_b", int'(cnt_b), 3);
        chk("sat_cnt_a", int'(cnt_a), 4);
        step(0,1,1,0,0,0); step(1,1,1,0,0,1);
        chk("clr_cnt_b", int'(cnt_b), 0);

        // Mid-stream reset after 10: the partial prefix must not complete a match.
        step(1,1,1,0,0,0); step(0,1,1,0,0,0);
        async_reset("r5");
        step(1,1,1,0,0,0);
        step(1,1,1,0,0,0); step(0,1,1,0,0,0); step(1,1,1,0,0,0);
        chk("post_rst_cnt", int'(cnt_a), 1);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom), ($urandom_range(0, 9) < 7), 1'($urandom),
                 ($urandom_range(0, 39) == 0), 3'($urandom), ($urandom_range(0, 29) == 0));
        end

        en = 1'b0; load = 1'b0; clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
